// File: rtl/ocx_leaf_rf_fifo_pkg.sv
// Shared helpers for the regfile FIFO sequencer: counter width, wrapped pointer increment, reset values.
// No logic of its own; latency and backpressure are defined by the users of this package.
package ocx_leaf_rf_fifo_pkg;

  localparam int unsigned RST_PTR       = 0;
  localparam int unsigned RST_CNT       = 0;
  localparam logic        RST_OUT_VALID = 1'b0;
  localparam logic        RST_FULL      = 1'b0;
  localparam logic        RST_AFULL     = 1'b0;

  // Occupancy reaches DEPTH+1 because the regfile output register is a storage stage.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 2);
  endfunction

  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/ocx_leaf_rf_ptr.sv
// Mod-DEPTH regfile pointer with increment and clear; clear wins over increment.
// Latency: new value visible the cycle after inc/clr. No backpressure of its own.
module ocx_leaf_rf_ptr #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  inc,
  input  logic                  clr,
  output logic [ADDR_WIDTH-1:0] ptr
);
  import ocx_leaf_rf_fifo_pkg::*;

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      ptr <= ADDR_WIDTH'(RST_PTR);
    end else if (inc) begin
      ptr <= ADDR_WIDTH'(ptr_next(32'(ptr), int'(DEPTH)));
    end
  end

endmodule

// File: rtl/ocx_leaf_regfile_fifo_ctl.sv
// FIFO sequencer over a dual-port regfile with registered read; head reaches out_valid 2 cycles after push.
// Pushes are dropped while full (no out_ready->full path); pops follow out_valid/out_ready. Macro OCX_LEAF_RF_FIFO_ERR_EN adds error status.
module ocx_leaf_regfile_fifo_ctl #(
  parameter int DEPTH        = 16,
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_wr,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   occupancy,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  flush,
  output logic                  rf_wr_en,
  output logic [ADDR_WIDTH-1:0] rf_wr_addr,
  output logic                  rf_rd_en,
  output logic [ADDR_WIDTH-1:0] rf_rd_addr,
  output logic                  rf_rd_rst_n
`ifdef OCX_LEAF_RF_FIFO_ERR_EN
  ,
  output logic                  err_overflow,
  output logic [7:0]            err_drop_cnt
`endif
);
  import ocx_leaf_rf_fifo_pkg::*;

  localparam int CW = cnt_width(DEPTH);

  logic [CW-1:0] arr_cnt;
  logic [CW-1:0] arr_cnt_nxt;
  logic [CW-1:0] occ_nxt;
  logic          out_valid_nxt;
  logic          wr_accept;
  logic          rd_issue;

  // The regfile must not move while reset or flush is discarding state.
  assign wr_accept = in_wr & ~full & ~flush & ~reset;
  assign rd_issue  = (arr_cnt != '0) & (~out_valid | out_ready) & ~flush & ~reset;

  assign rf_wr_en    = wr_accept;
  assign rf_rd_en    = rd_issue;
  assign rf_rd_rst_n = ~reset;
  assign occupancy   = (ADDR_WIDTH+1)'(arr_cnt + CW'(out_valid));

  always_comb begin
    arr_cnt_nxt   = arr_cnt + CW'(wr_accept) - CW'(rd_issue);
    out_valid_nxt = rd_issue ? 1'b1 : (out_ready ? 1'b0 : out_valid);
    if (flush) begin
      arr_cnt_nxt   = '0;
      out_valid_nxt = 1'b0;
    end
    occ_nxt = arr_cnt_nxt + CW'(out_valid_nxt);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      arr_cnt     <= CW'(RST_CNT);
      out_valid   <= RST_OUT_VALID;
      full        <= RST_FULL;
      almost_full <= RST_AFULL;
    end else begin
      arr_cnt     <= arr_cnt_nxt;
      out_valid   <= out_valid_nxt;
      full        <= (occ_nxt == CW'(DEPTH + 1));
      almost_full <= (occ_nxt >= CW'(AFULL_THRESH));
    end
  end

  ocx_leaf_rf_ptr #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .clock (clock),
    .reset (reset),
    .inc   (wr_accept),
    .clr   (flush),
    .ptr   (rf_wr_addr)
  );

  ocx_leaf_rf_ptr #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .clock (clock),
    .reset (reset),
    .inc   (rd_issue),
    .clr   (flush),
    .ptr   (rf_rd_addr)
  );

`ifdef OCX_LEAF_RF_FIFO_ERR_EN
  // Sticky across flush so software can still see a loss that happened before it.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_overflow <= 1'b0;
      err_drop_cnt <= 8'd0;
    end else if (in_wr && full) begin
      err_overflow <= 1'b1;
      if (err_drop_cnt != 8'hFF) begin
        err_drop_cnt <= err_drop_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ocx_leaf_regfile_fifo_ctl.sv
// Bench: two sequencers (DEPTH 16 and DEPTH 12) each driving a behavioural 1-cycle regfile,
// with scoreboard queues checked on every out_valid/out_ready handshake.
module tb_ocx_leaf_regfile_fifo_ctl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic       a_in_wr, a_full, a_af, a_ov, a_or, a_flush, a_wr_en, a_rd_en, a_rd_rst_n;
  logic [4:0] a_occ;
  logic [3:0] a_wr_addr, a_rd_addr;
  logic [7:0] a_in_data, a_out_data;
  logic [7:0] mem_a [0:15];

  logic       b_in_wr, b_full, b_af, b_ov, b_or, b_flush, b_wr_en, b_rd_en, b_rd_rst_n;
  logic [4:0] b_occ;
  logic [3:0] b_wr_addr, b_rd_addr;
  logic [7:0] b_in_data, b_out_data;
  logic [7:0] mem_b [0:15];

`ifdef OCX_LEAF_RF_FIFO_ERR_EN
  logic       a_err, b_err;
  logic [7:0] a_drop, b_drop;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int b_pops = 0;
  logic [7:0] sb_a [$];
  logic [7:0] sb_b [$];

  ocx_leaf_regfile_fifo_ctl #(.DEPTH(16), .ADDR_WIDTH(4), .AFULL_THRESH(12)) u_dut_a (
    .clock(clock), .reset(reset), .in_wr(a_in_wr), .full(a_full), .almost_full(a_af),
    .occupancy(a_occ), .out_valid(a_ov), .out_ready(a_or), .flush(a_flush),
    .rf_wr_en(a_wr_en), .rf_wr_addr(a_wr_addr), .rf_rd_en(a_rd_en), .rf_rd_addr(a_rd_addr),
    .rf_rd_rst_n(a_rd_rst_n)
`ifdef OCX_LEAF_RF_FIFO_ERR_EN
    , .err_overflow(a_err), .err_drop_cnt(a_drop)
`endif
  );

  ocx_leaf_regfile_fifo_ctl #(.DEPTH(12), .ADDR_WIDTH(4), .AFULL_THRESH(9)) u_dut_b (
    .clock(clock), .reset(reset), .in_wr(b_in_wr), .full(b_full), .almost_full(b_af),
    .occupancy(b_occ), .out_valid(b_ov), .out_ready(b_or), .flush(b_flush),
    .rf_wr_en(b_wr_en), .rf_wr_addr(b_wr_addr), .rf_rd_en(b_rd_en), .rf_rd_addr(b_rd_addr),
    .rf_rd_rst_n(b_rd_rst_n)
`ifdef OCX_LEAF_RF_FIFO_ERR_EN
    , .err_overflow(b_err), .err_drop_cnt(b_drop)
`endif
  );

  // Behavioural regfiles: write port A, registered read port B with reset.
  always @(posedge clock) begin
    if (a_wr_en) mem_a[a_wr_addr] <= a_in_data;
    if (!a_rd_rst_n) a_out_data <= 8'h00;
    else if (a_rd_en) a_out_data <= mem_a[a_rd_addr];
    if (b_wr_en) mem_b[b_wr_addr] <= b_in_data;
    if (!b_rd_rst_n) b_out_data <= 8'h00;
    else if (b_rd_en) b_out_data <= mem_b[b_rd_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    logic [7:0] exp_d;
    if (!reset && a_ov && a_or) begin
      if (sb_a.size() == 0) chk("a_sb_underflow", sb_a.size(), 1);
      else begin
        exp_d = sb_a.pop_front();
        chk("a_data", a_out_data, exp_d);
      end
    end
    if (!reset && b_ov && b_or) begin
      if (sb_b.size() == 0) chk("b_sb_underflow", sb_b.size(), 1);
      else begin
        exp_d = sb_b.pop_front();
        chk("b_data", b_out_data, exp_d);
      end
      b_pops++;
    end
  end

  initial begin
    int sent;
    int cyc;
    a_in_wr = 0; a_or = 0; a_flush = 0; a_in_data = 0;
    b_in_wr = 0; b_or = 0; b_flush = 0; b_in_data = 0;
    step(); step();
    chk("rst_occ", a_occ, 0);
    chk("rst_full", a_full, 0);
    chk("rst_af", a_af, 0);
    chk("rst_ov", a_ov, 0);
    chk("rst_rd_rst_n", a_rd_rst_n, 0);
    chk("rst_wen", a_wr_en, 0);
    reset = 0;
    #1;
    chk("rel_rd_rst_n", a_rd_rst_n, 1);
    step();

    // Fill to DEPTH+1 with the consumer stalled.
    for (int i = 0; i < 17; i++) begin
      a_in_wr = 1; a_in_data = 8'(i);
      #1;
      chk("fill_wen", a_wr_en, 1);
      chk("fill_waddr", a_wr_addr, i % 16);
      sb_a.push_back(8'(i));
      step();
      chk("fill_occ", a_occ, i + 1);
      chk("fill_af", a_af, (i + 1 >= 12));
      chk("fill_full", a_full, (i == 16));
    end

    a_in_data = 8'hAA;
    #1;
    chk("ovf_wen", a_wr_en, 0);
    step();
    a_in_wr = 0;
    chk("ovf_occ", a_occ, 17);
    chk("ovf_full", a_full, 1);
    chk("ovf_waddr", a_wr_addr, 1);
    chk("ovf_raddr", a_rd_addr, 1);
`ifdef OCX_LEAF_RF_FIFO_ERR_EN
    chk("ovf_err", a_err, 1);
    chk("ovf_drop", a_drop, 1);
`endif

    a_in_wr = 1; a_in_data = 8'hAB; a_or = 1;
    #1;
    chk("ovf_rdy_wen", a_wr_en, 0);
    step();
    a_in_wr = 0;
`ifdef OCX_LEAF_RF_FIFO_ERR_EN
    chk("ovf_drop2", a_drop, 2);
`endif
    for (int j = 1; j <= 16; j++) begin
      chk("drain_vld", a_ov, 1);
      step();
    end
    chk("drain_ov", a_ov, 0);
    chk("drain_occ", a_occ, 0);
    chk("drain_sb", sb_a.size(), 0);

    // Streaming with the consumer always ready.
    for (int k = 0; k < 100; k++) begin
      a_in_wr = 1; a_in_data = 8'(k + 32);
      sb_a.push_back(8'(k + 32));
      step();
      if (k == 0) begin
        chk("st_ov0", a_ov, 0);
        chk("st_occ0", a_occ, 1);
      end else begin
        chk("st_vld", a_ov, 1);
        chk("st_occ", a_occ, 2);
      end
    end
    a_in_wr = 0;
    repeat (4) step();
    chk("st_sb", sb_a.size(), 0);
    chk("st_occ_end", a_occ, 0);

    // Flush beats a same-cycle push and pop.
    a_or = 0;
    for (int i = 0; i < 5; i++) begin
      a_in_wr = 1; a_in_data = 8'(8'h60 + i);
      sb_a.push_back(8'(8'h60 + i));
      step();
    end
    a_in_wr = 0;
    chk("fl_pre_occ", a_occ, 5);
    a_flush = 1; a_in_wr = 1; a_in_data = 8'hEE; a_or = 1;
    #1;
    chk("fl_wen", a_wr_en, 0);
    chk("fl_ren", a_rd_en, 0);
    step();
    a_flush = 0; a_in_wr = 0; a_or = 0;
    sb_a.delete();
    chk("fl_occ", a_occ, 0);
    chk("fl_ov", a_ov, 0);
    chk("fl_full", a_full, 0);
    chk("fl_waddr", a_wr_addr, 0);
    chk("fl_raddr", a_rd_addr, 0);
`ifdef OCX_LEAF_RF_FIFO_ERR_EN
    chk("fl_err_sticky", a_err, 1);
`endif
    a_in_wr = 1; a_in_data = 8'h55;
    #1;
    chk("fl_push_addr", a_wr_addr, 0);
    sb_a.push_back(8'h55);
    step();
    a_in_wr = 0; a_or = 1;
    repeat (3) step();
    chk("fl_sb", sb_a.size(), 0);
    a_or = 0;

    // Reset mid-stream.
    for (int i = 0; i < 5; i++) begin
      a_in_wr = 1; a_in_data = 8'(8'h70 + i);
      sb_a.push_back(8'(8'h70 + i));
      step();
    end
    a_in_data = 8'h99; reset = 1;
    #1;
    chk("rs_wen", a_wr_en, 0);
    chk("rs_rd_rst_n", a_rd_rst_n, 0);
    step();
    sb_a.delete();
    a_in_wr = 0;
    chk("rs_occ", a_occ, 0);
    chk("rs_ov", a_ov, 0);
    chk("rs_full", a_full, 0);
    chk("rs_af", a_af, 0);
    chk("rs_waddr", a_wr_addr, 0);
    chk("rs_raddr", a_rd_addr, 0);
    chk("rs_dout", a_out_data, 0);
`ifdef OCX_LEAF_RF_FIFO_ERR_EN
    chk("rs_err", a_err, 0);
    chk("rs_drop", a_drop, 0);
`endif
    reset = 0;
    #1;
    chk("rs_rel_rd_rst_n", a_rd_rst_n, 1);
    step();
    a_in_wr = 1; a_in_data = 8'h77;
    #1;
    chk("rs_push_addr", a_wr_addr, 0);
    sb_a.push_back(8'h77);
    step();
    a_in_wr = 0; a_or = 1;
    repeat (3) step();
    chk("rs_sb", sb_a.size(), 0);
    a_or = 0;

    // Non-power-of-two depth: 40 items with a random consumer.
    sent = 0; cyc = 0; b_pops = 0;
    while (b_pops < 40 && cyc < 2000) begin
      b_or = 1'($urandom_range(0, 1));
      b_in_wr = (sent < 40) && (sent - b_pops < 10);
      if (b_in_wr) begin
        b_in_data = 8'(sent + 64);
        #1;
        chk("b_wen", b_wr_en, 1);
        chk("b_waddr", b_wr_addr, sent % 12);
        sb_b.push_back(8'(sent + 64));
        sent++;
      end else begin
        #1;
      end
      chk("b_waddr_rng", (b_wr_addr <= 4'd11), 1);
      chk("b_raddr_rng", (b_rd_addr <= 4'd11), 1);
      chk("b_not_full", b_full, 0);
      step();
      cyc++;
    end
    b_in_wr = 0; b_or = 0;
    chk("b_items", b_pops, 40);
    chk("b_sb", sb_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
